// File: rtl/timer_pkg.sv
// Shared widths, register map, control layout and FSM state types for the timer.
package timer_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 4'h0;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD = 4'h4;
    localparam logic [ADDR_W-1:0] ADDR_COUNT  = 4'h8;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 4'hC;

    localparam int unsigned CTRL_EN_BIT          = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT      = 1;
    localparam int unsigned CTRL_AUTO_RELOAD_BIT = 2;
    localparam int unsigned STATUS_EXP_BIT       = 0;

    localparam logic [1:0]        RESP_OKAY  = 2'b00;
    localparam logic [DATA_W-1:0] PERIOD_RST = 32'hFFFF_FFFF;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

    typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} r_state_t;

    // Word-align a byte address; the two low bits never select a register.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/timer_axil_regs_if.sv
// AXI4-Lite S00_AXI channel bundle with master and slave views.
interface timer_axil_regs_if;
    import timer_pkg::*;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/timer_counter.sv
// Free-running up-counter compared against PERIOD; owns COUNT and the sticky EXP flag.
module timer_counter
    import timer_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              auto_reload,
    input  logic [DATA_W-1:0] period,
    input  logic              clr_exp,
    input  logic              load_zero,
    output logic [DATA_W-1:0] count,
    output logic              exp,
    output logic              en_clr
);

    logic expire_c;

    // >= compare so a PERIOD lowered below COUNT expires at once and COUNT never wraps.
    assign expire_c = en && (count >= period);
    // One-shot mode: the expiry edge also drops EN in the register file.
    assign en_clr   = expire_c && !auto_reload;

    // COUNT and EXP update; an expiry outranks a same-cycle EXP clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
            exp   <= 1'b0;
        end else begin
            if (load_zero) begin
                count <= '0;
            end else if (expire_c) begin
                if (auto_reload) begin
                    count <= '0;
                end
            end else if (en) begin
                count <= count + DATA_W'(1);
            end

            if (expire_c) begin
                exp <= 1'b1;
            end else if (clr_exp) begin
                exp <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/timer_axil_regs.sv
// AXI4-Lite slave for the timer: handshake FSMs, CTRL/PERIOD registers, read mux and irq.
module timer_axil_regs
    import timer_pkg::*;
(
    input  logic               ACLK,
    input  logic               ARESETN,
    timer_axil_regs_if.slave   s_axi,
    output logic               irq
);

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              wr_ready_q, wr_ready_d;
    logic              bvalid_q, bvalid_d;
    logic              arready_q, arready_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_fire_c;
    logic              rd_fire_c;

    ctrl_t             ctrl_q;
    logic [DATA_W-1:0] period_q;
    logic              irq_q;

    logic [ADDR_W-1:0] wr_addr_c;
    logic              wr_ctrl_c, wr_period_c, wr_status_c;
    logic              load_zero_c, clr_exp_c;
    logic [DATA_W-1:0] rd_mux_c;

    logic [DATA_W-1:0] count;
    logic              exp;
    logic              en_clr;

    logic              unused_bits;

    assign s_axi.awready = wr_ready_q;
    assign s_axi.wready  = wr_ready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = RESP_OKAY;
    assign s_axi.arready = arready_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rdata_q;
    assign s_axi.rresp   = RESP_OKAY;
    assign irq           = irq_q;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    // Write FSM next state: AW and W are only ever accepted together.
    always_comb begin
        w_state_d  = w_state_q;
        wr_ready_d = 1'b0;
        bvalid_d   = 1'b0;
        wr_fire_c  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (s_axi.awvalid && s_axi.wvalid) begin
                    w_state_d  = W_ACK;
                    wr_ready_d = 1'b1;
                end
            end
            W_ACK: begin
                if (s_axi.awvalid && s_axi.wvalid) begin
                    wr_fire_c = 1'b1;
                    w_state_d = W_RESP;
                    bvalid_d  = 1'b1;
                end else begin
                    w_state_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM next state: one ARREADY pulse, then RVALID held until RREADY.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = 1'b0;
        rvalid_d  = 1'b0;
        rd_fire_c = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    r_state_d = R_ACK;
                    arready_d = 1'b1;
                end
            end
            R_ACK: begin
                if (s_axi.arvalid) begin
                    rd_fire_c = 1'b1;
                    r_state_d = R_DATA;
                    rvalid_d  = 1'b1;
                end else begin
                    r_state_d = R_IDLE;
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    r_state_d = R_IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Handshake state and registered channel outputs; reset drops any pending response.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            wr_ready_q <= 1'b0;
            bvalid_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            wr_ready_q <= wr_ready_d;
            bvalid_q   <= bvalid_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
        end
    end

    // Write decode for the accepted beat.
    always_comb begin
        wr_addr_c   = word_addr(s_axi.awaddr);
        wr_ctrl_c   = wr_fire_c && (wr_addr_c == ADDR_CTRL);
        wr_period_c = wr_fire_c && (wr_addr_c == ADDR_PERIOD);
        wr_status_c = wr_fire_c && (wr_addr_c == ADDR_STATUS);
        load_zero_c = wr_ctrl_c && s_axi.wstrb[0] && s_axi.wdata[CTRL_EN_BIT] && !ctrl_q.en;
        clr_exp_c   = wr_status_c && s_axi.wstrb[0] && s_axi.wdata[STATUS_EXP_BIT];
    end

    // CTRL/PERIOD storage and registered irq; a bus write to CTRL beats the expiry EN clear.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            ctrl_q   <= '0;
            period_q <= PERIOD_RST;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl_c && s_axi.wstrb[0]) begin
                ctrl_q.en          <= s_axi.wdata[CTRL_EN_BIT];
                ctrl_q.irq_en      <= s_axi.wdata[CTRL_IRQ_EN_BIT];
                ctrl_q.auto_reload <= s_axi.wdata[CTRL_AUTO_RELOAD_BIT];
            end else if (en_clr) begin
                ctrl_q.en <= 1'b0;
            end

            if (wr_period_c) begin
                for (int unsigned b = 0; b < STRB_W; b++) begin
                    if (s_axi.wstrb[b]) begin
                        period_q[8*b +: 8] <= s_axi.wdata[8*b +: 8];
                    end
                end
            end

            irq_q <= exp && ctrl_q.irq_en;
        end
    end

    // Read mux over the four registers.
    always_comb begin
        rd_mux_c = '0;
        case (word_addr(s_axi.araddr))
            ADDR_CTRL:   rd_mux_c = DATA_W'(ctrl_q);
            ADDR_PERIOD: rd_mux_c = period_q;
            ADDR_COUNT:  rd_mux_c = count;
            ADDR_STATUS: rd_mux_c = DATA_W'(exp);
            default:     rd_mux_c = '0;
        endcase
    end

    // Read data captured on the AR handshake edge and held while RVALID waits.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rdata_q <= '0;
        end else if (rd_fire_c) begin
            rdata_q <= rd_mux_c;
        end
    end

    timer_counter u_counter (
        .clk         (ACLK),
        .rst_n       (ARESETN),
        .en          (ctrl_q.en),
        .auto_reload (ctrl_q.auto_reload),
        .period      (period_q),
        .clr_exp     (clr_exp_c),
        .load_zero   (load_zero_c),
        .count       (count),
        .exp         (exp),
        .en_clr      (en_clr)
    );

endmodule

// File: tb/tb_timer_axil_regs.sv
// Scoreboard bench for timer_axil_regs: drivers queue expected B/R responses, a monitor compares them.
module tb_timer_axil_regs;
    import timer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    timer_axil_regs_if bus ();

    timer_axil_regs dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .s_axi   (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [1:0]  exp_b_q[$];
    logic [31:0] exp_r_q[$];
    string       exp_r_name[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
        end
    endtask

    // Monitor: compare every completed B and R handshake against the queued expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.bvalid && bus.bready) begin
                if (exp_b_q.size() == 0) check("unexpected_bresp", 32'd1, 32'd0);
                else check("bresp", 32'(bus.bresp), 32'(exp_b_q.pop_front()));
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_r_q.size() == 0) begin
                    check("unexpected_rdata", 32'd1, 32'd0);
                end else begin
                    check(exp_r_name.pop_front(), bus.rdata, exp_r_q.pop_front());
                    check("rresp", 32'(bus.rresp), 32'(RESP_OKAY));
                end
            end
        end
    end

    task automatic wait_awready(input string name);
        int t = 0;
        do begin
            @(posedge clk); #1; t++;
        end while (!bus.awready && t < 40);
        if (!bus.awready) check(name, 32'd0, 32'd1);
    endtask

    task automatic wait_bdone();
        int t = 0;
        while (bus.bvalid && t < 40) begin
            @(posedge clk); #1; t++;
        end
        if (bus.bvalid) check("b_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_rdone();
        int t = 0;
        while (bus.rvalid && t < 40) begin
            @(posedge clk); #1; t++;
        end
        if (bus.rvalid) check("r_timeout", 32'd1, 32'd0);
    endtask

    // Called 1ns after a posedge; register update lands 2 edges later, returns 1ns after the B edge.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp_b_q.push_back(RESP_OKAY);
        wait_awready("aw_timeout");
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_bdone();
    endtask

    // Called 1ns after a posedge; data is captured 2 edges later, returns 1ns after the R edge.
    task automatic axi_read(input logic [3:0] addr, input logic [31:0] want, input string name);
        int t = 0;
        bus.araddr = addr; bus.arvalid = 1'b1;
        exp_r_q.push_back(want); exp_r_name.push_back(name);
        do begin
            @(posedge clk); #1; t++;
        end while (!bus.arready && t < 40);
        if (!bus.arready) check("ar_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        wait_rdone();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
        bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

        // Reset state of every response-side output.
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        check("rst_bresp",   32'(bus.bresp),   32'd0);
        check("rst_rresp",   32'(bus.rresp),   32'd0);
        check("rst_irq",     32'(irq),         32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        axi_read(4'h0, 32'h0000_0000, "rst_ctrl");
        axi_read(4'h4, 32'hFFFF_FFFF, "rst_period");
        axi_read(4'h8, 32'h0000_0000, "rst_count");
        axi_read(4'hC, 32'h0000_0000, "rst_status");

        // Byte strobes on PERIOD, reserved CTRL bits, read-only COUNT.
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF);
        axi_write(4'h4, 32'h0000_0004, 4'b0011);
        axi_read(4'h4, 32'hFFFF_0004, "period_wstrb");
        axi_write(4'h4, 32'h0000_0004, 4'hF);
        axi_read(4'h5, 32'h0000_0004, "period_lowbits_ignored");
        axi_write(4'h0, 32'hFFFF_FFF8, 4'hF);
        axi_read(4'h0, 32'h0000_0000, "ctrl_reserved");
        axi_write(4'h8, 32'h0000_1234, 4'hF);
        axi_read(4'h8, 32'h0000_0000, "count_ro");

        // Auto-reload, PERIOD=4: EN edge E0, EXP at E5, irq at E6; COUNT after edge k is k mod 5.
        axi_write(4'h0, 32'h0000_0007, 4'hF);
        repeat (4) @(posedge clk);
        #1;
        check("irq_before_exp", 32'(irq), 32'd0);
        @(posedge clk); #1;
        check("irq_rise", 32'(irq), 32'd1);
        axi_read(4'h8, 32'd2, "count_e8");
        axi_read(4'h8, 32'd0, "count_e11");
        axi_read(4'h8, 32'd3, "count_e14");
        axi_read(4'h8, 32'd1, "count_e17");
        axi_read(4'h8, 32'd4, "count_e20");
        axi_write(4'h0, 32'h0000_0006, 4'hF);
        check("irq_held", 32'(irq), 32'd1);
        axi_write(4'hC, 32'h0000_0001, 4'hF);
        check("irq_fall_w1c", 32'(irq), 32'd0);
        axi_read(4'hC, 32'd0, "status_cleared");
        axi_read(4'h0, 32'd6, "ctrl_disabled");

        // One-shot, PERIOD=2: expiry at E3 clears EN and holds COUNT.
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h0, 32'h0000_0003, 4'hF);
        repeat (3) @(posedge clk);
        #1;
        check("irq_oneshot", 32'(irq), 32'd1);
        axi_read(4'h0, 32'h0000_0002, "ctrl_en_cleared");
        axi_read(4'h8, 32'd2, "count_held");
        axi_read(4'hC, 32'd1, "status_oneshot");

        // PERIOD=0 with reload expires every cycle, so a W1C always loses to the set.
        axi_write(4'h4, 32'd0, 4'hF);
        axi_write(4'h0, 32'h0000_0005, 4'hF);
        axi_write(4'hC, 32'h0000_0001, 4'hF);
        axi_read(4'hC, 32'd1, "status_set_wins");
        axi_read(4'h8, 32'd0, "count_period0");
        check("irq_masked", 32'(irq), 32'd0);
        axi_write(4'h0, 32'h0000_0002, 4'hF);
        check("irq_unmasked", 32'(irq), 32'd1);

        // Back-pressure: B and R stalled, a second write waits behind the first response.
        axi_write(4'h4, 32'h0000_0077, 4'hF);
        bus.bready = 1'b0; bus.rready = 1'b0;
        bus.awaddr = 4'h4; bus.wdata = 32'h0000_0055; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        exp_b_q.push_back(RESP_OKAY);
        bus.araddr = 4'h4; bus.arvalid = 1'b1;
        exp_r_q.push_back(32'h0000_0077); exp_r_name.push_back("stall_rdata");
        wait_awready("stall_aw_timeout");
        check("stall_arready", 32'(bus.arready), 32'd1);
        @(posedge clk); #1;
        bus.arvalid = 1'b0;
        bus.wdata = 32'h0000_0066;
        exp_b_q.push_back(RESP_OKAY);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_bvalid",  32'(bus.bvalid),  32'd1);
            check("stall_rvalid",  32'(bus.rvalid),  32'd1);
            check("stall_rstable", bus.rdata,        32'h0000_0077);
            check("stall_no_aw",   32'(bus.awready), 32'd0);
        end
        bus.bready = 1'b1;
        wait_awready("second_aw_timeout");
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        wait_bdone();
        bus.rready = 1'b1;
        wait_rdone();
        axi_read(4'h4, 32'h0000_0066, "period_second_write");

        // AW without W is never accepted.
        bus.awaddr = 4'h4; bus.wdata = 32'h0000_0011; bus.awvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("aw_only_awready", 32'(bus.awready), 32'd0);
            check("aw_only_wready",  32'(bus.wready),  32'd0);
        end
        @(posedge clk); #1;
        bus.awvalid = 1'b0;
        axi_read(4'h4, 32'h0000_0066, "period_aw_only");

        // Reset with BVALID pending at COUNT=3: response dropped, counter and irq cleared.
        axi_write(4'h4, 32'd100, 4'hF);
        bus.bready = 1'b0;
        bus.awaddr = 4'h0; bus.wdata = 32'h0000_0003; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        wait_awready("rst_aw_timeout");
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
        check("pre_rst_irq",    32'(irq),        32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
        check("mid_rst_irq",    32'(irq),        32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; bus.bready = 1'b1;
        @(posedge clk); #1;
        check("post_rst_bvalid", 32'(bus.bvalid), 32'd0);
        axi_read(4'h8, 32'd0,          "post_rst_count");
        axi_read(4'h0, 32'd0,          "post_rst_ctrl");
        axi_read(4'h4, 32'hFFFF_FFFF,  "post_rst_period");
        axi_read(4'hC, 32'd0,          "post_rst_status");

        repeat (2) @(posedge clk);
        #1;
        check("b_queue_drained", 32'(exp_b_q.size()), 32'd0);
        check("r_queue_drained", 32'(exp_r_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
